// File: rtl/ecc_decoding_pipe_pkg.sv
// ==========================================================================
// Module : ecc_pkg
// Brief  : SRAM mode codes and the per-channel ECC select function.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

package ecc_pkg;

    typedef enum logic [2:0] {
        TDP_NONSPLIT = 3'd0,
        TDP_SPLIT    = 3'd1,
        SDP_NONSPLIT = 3'd2,
        SDP_SPLIT    = 3'd3,
        CASCADE_LOW  = 3'd4,
        CASCADE_UP   = 3'd5,
        FIFO_SYNC    = 3'd6,
        FIFO_ASYNC   = 3'd7
    } sram_mode_e;

    // Channel c = 2*port + half; odd channels are the upper word of a port.
    function automatic logic ecc_sel(input logic [2:0] mode, input logic [1:0] en,
                                     input int unsigned c);
        logic odd_sel;
        case (mode)
            TDP_NONSPLIT, SDP_NONSPLIT: odd_sel = en[0];
            SDP_SPLIT:                  odd_sel = en[1];
            default:                    odd_sel = 1'b0;
        endcase
        return ((c % 2) == 0) ? en[0] : odd_sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_decoding_pipe_if.sv
// ==========================================================================
// Module : ecc_decoding_pipe_if
// Brief  : Read-data beat bus into and out of the ECC decoding pipe.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

interface ecc_decoding_pipe_if #(
    parameter int DATA_W = 20,
    parameter int NUM_CH = 4
);
    logic                     valid_i;
    logic                     ready_o;
    logic [NUM_CH*DATA_W-1:0] data_i;
    logic [NUM_CH*DATA_W-1:0] data_ecc_i;
    logic [NUM_CH-1:0]        sbe_i;
    logic [NUM_CH-1:0]        dbe_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [NUM_CH*DATA_W-1:0] data_o;
    logic [NUM_CH-1:0]        err_o;

    modport slave (
        input  valid_i, data_i, data_ecc_i, sbe_i, dbe_i, ready_i,
        output ready_o, valid_o, data_o, err_o
    );

    modport master (
        output valid_i, data_i, data_ecc_i, sbe_i, dbe_i, ready_i,
        input  ready_o, valid_o, data_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/ecc_decoding_pipe_err_counter.sv
// ==========================================================================
// Module : ecc_err_counter
// Brief  : Saturating event counter with synchronous clear (clear wins).
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module ecc_err_counter #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             inc_i,
    input  wire logic             clr_i,
    output      logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

`default_nettype wire

// File: rtl/ecc_decoding_pipe.sv
// ==========================================================================
// Module : ecc_decoding_pipe
// Brief  : Registered ECC/raw data select with skid buffer and optional
//          per-channel error counters (macro ECC_ERR_CNT_EN).
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module ecc_decoding_pipe
    import ecc_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic [2:0]        cfg_sram_mode_i,
    input  wire logic [1:0]        cfg_ecc_enable_i,
    ecc_decoding_pipe_if.slave     bus,
    input  wire logic              cnt_clr_i,
    output      logic [NUM_CH*CNT_W-1:0] sbe_cnt_o,
    output      logic [NUM_CH*CNT_W-1:0] dbe_cnt_o,
    output      logic              err_irq_o
);
    localparam int BUS_W = NUM_CH*DATA_W;

    logic [NUM_CH-1:0] sel_w;
    logic [BUS_W-1:0]  beat_data_w;
    logic [NUM_CH-1:0] beat_err_w;
    logic              accept_w;

    logic              main_vld_q, main_vld_d;
    logic [BUS_W-1:0]  main_data_q, main_data_d;
    logic [NUM_CH-1:0] main_err_q, main_err_d;
    logic              skid_full_q, skid_full_d;
    logic [BUS_W-1:0]  skid_data_q, skid_data_d;
    logic [NUM_CH-1:0] skid_err_q, skid_err_d;
    logic              ready_q;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_sel
            assign sel_w[c] = ecc_sel(cfg_sram_mode_i, cfg_ecc_enable_i, c);
            assign beat_data_w[c*DATA_W +: DATA_W] = sel_w[c] ?
                bus.data_ecc_i[c*DATA_W +: DATA_W] : bus.data_i[c*DATA_W +: DATA_W];
        end
    endgenerate

    assign beat_err_w = sel_w & bus.dbe_i;
    assign accept_w   = bus.valid_i & ready_q;

    // ready_q mirrors !skid_full_q, so skid is never loaded while occupied.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        if (!main_vld_q || bus.ready_i) begin
            if (skid_full_q) begin
                main_vld_d  = 1'b1;
                main_data_d = skid_data_q;
                main_err_d  = skid_err_q;
                skid_full_d = 1'b0;
            end else if (accept_w) begin
                main_vld_d  = 1'b1;
                main_data_d = beat_data_w;
                main_err_d  = beat_err_w;
            end else begin
                main_vld_d  = 1'b0;
            end
        end else if (accept_w) begin
            skid_full_d = 1'b1;
            skid_data_d = beat_data_w;
            skid_err_d  = beat_err_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            main_err_q  <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= '0;
            ready_q     <= 1'b1;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            ready_q     <= !skid_full_d;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = main_vld_q;
    assign bus.data_o  = main_data_q;
    assign bus.err_o   = main_err_q;

`ifdef ECC_ERR_CNT_EN
    logic [NUM_CH-1:0] inc_sbe_w;
    logic [NUM_CH-1:0] inc_dbe_w;
    logic              irq_q;

    // dbe takes precedence, so a beat bumps at most one counter per channel.
    assign inc_dbe_w = {NUM_CH{accept_w}} & sel_w & bus.dbe_i;
    assign inc_sbe_w = {NUM_CH{accept_w}} & sel_w & bus.sbe_i & ~bus.dbe_i;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
            ecc_err_counter #(.CNT_W(CNT_W)) u_sbe_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .inc_i (inc_sbe_w[c]),
                .clr_i (cnt_clr_i),
                .cnt_o (sbe_cnt_o[c*CNT_W +: CNT_W])
            );
            ecc_err_counter #(.CNT_W(CNT_W)) u_dbe_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .inc_i (inc_dbe_w[c]),
                .clr_i (cnt_clr_i),
                .cnt_o (dbe_cnt_o[c*CNT_W +: CNT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            irq_q <= 1'b0;
        end else if (|inc_dbe_w) begin
            irq_q <= 1'b1;
        end
    end

    assign err_irq_o = irq_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^{cnt_clr_i, bus.sbe_i};
    assign sbe_cnt_o    = '0;
    assign dbe_cnt_o    = '0;
    assign err_irq_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ecc_decoding_pipe.sv
// ==========================================================================
// Module : tb_ecc_decoding_pipe
// Brief  : Directed self-checking bench for ecc_decoding_pipe.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module tb_ecc_decoding_pipe;
    localparam int DATA_W = 20;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
`ifdef ECC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [79:0] RAW = {4{20'h05555}};
    localparam logic [79:0] ECC = {4{20'h0AAAA}};

    logic                    clk = 1'b0;
    logic                    rst;
    logic [2:0]              mode;
    logic [1:0]              en;
    logic                    cnt_clr;
    logic [NUM_CH*CNT_W-1:0] sbe_cnt;
    logic [NUM_CH*CNT_W-1:0] dbe_cnt;
    logic                    irq;

    int checks = 0;
    int errors = 0;

    ecc_decoding_pipe_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    ecc_decoding_pipe #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_sram_mode_i  (mode),
        .cfg_ecc_enable_i (en),
        .bus              (bus.slave),
        .cnt_clr_i        (cnt_clr),
        .sbe_cnt_o        (sbe_cnt),
        .dbe_cnt_o        (dbe_cnt),
        .err_irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready_o); end
        checks++; if (bus.data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.data_o); end
        checks++; if ({bus.err_o, irq} !== '0) begin errors++; $display("FAIL reset_err got %b/%b exp 0", bus.err_o, irq); end
        checks++; if ({sbe_cnt, dbe_cnt} !== '0) begin errors++; $display("FAIL reset_cnt got %h %h exp 0", sbe_cnt, dbe_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_select();
        bus.data_i = RAW; bus.data_ecc_i = ECC;
        mode = 3'd2; en = 2'b01; bus.valid_i = 1'b1; bus.ready_i = 1'b1;
        step();
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL m2_valid got %b exp 1", bus.valid_o); end
        checks++; if (bus.data_o !== ECC) begin errors++; $display("FAIL m2_data got %h exp %h", bus.data_o, ECC); end
        mode = 3'd3; en = 2'b10;
        step();
        checks++; if (bus.data_o !== {20'h0AAAA, 20'h05555, 20'h0AAAA, 20'h05555}) begin
            errors++; $display("FAIL m3_data got %h exp 0aaaa055550aaaa05555", bus.data_o); end
        mode = 3'd5; en = 2'b11;
        step();
        checks++; if (bus.data_o !== {20'h05555, 20'h0AAAA, 20'h05555, 20'h0AAAA}) begin
            errors++; $display("FAIL m5_data got %h exp 055550aaaa055550aaaa", bus.data_o); end
        bus.valid_i = 1'b0;
        step();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", bus.valid_o); end
    endtask

    task automatic test_stall();
        mode = 3'd0; en = 2'b00; bus.ready_i = 1'b0; bus.valid_i = 1'b1;
        bus.data_i = {4{20'h00101}};
        step();
        checks++; if ({bus.valid_o, bus.ready_o} !== 2'b11) begin errors++; $display("FAIL stall_b1 got v%b r%b exp v1 r1", bus.valid_o, bus.ready_o); end
        bus.data_i = {4{20'h00102}};
        step();
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", bus.ready_o); end
        checks++; if (bus.data_o !== {4{20'h00101}}) begin errors++; $display("FAIL stall_hold got %h exp b1", bus.data_o); end
        bus.data_i = {4{20'h00103}};
        step();
        step();
        checks++; if ({bus.valid_o, bus.ready_o} !== 2'b10 || bus.data_o !== {4{20'h00101}}) begin
            errors++; $display("FAIL stall_hold2 got v%b r%b %h exp v1 r0 b1", bus.valid_o, bus.ready_o, bus.data_o); end
        bus.ready_i = 1'b1;
        step();
        checks++; if (bus.data_o !== {4{20'h00102}} || bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL drain_b2 got %h r%b exp b2 r1", bus.data_o, bus.ready_o); end
        step();
        bus.valid_i = 1'b0;
        checks++; if (bus.data_o !== {4{20'h00103}} || bus.valid_o !== 1'b1) begin
            errors++; $display("FAIL drain_b3 got %h v%b exp b3 v1", bus.data_o, bus.valid_o); end
        step();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL drain_end got %b exp 0", bus.valid_o); end
    endtask

    task automatic test_counters();
        bus.data_i = RAW; bus.data_ecc_i = ECC;
        mode = 3'd2; en = 2'b01; bus.ready_i = 1'b1;
        bus.sbe_i = 4'b0001; bus.dbe_i = 4'b0001; bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        checks++; if (bus.err_o !== 4'b0001) begin errors++; $display("FAIL err_o got %b exp 0001", bus.err_o); end
        checks++; if (dbe_cnt[7:0] !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL dbe_cnt0 got %0d exp %0d", dbe_cnt[7:0], CNT_EN); end
        checks++; if (sbe_cnt[7:0] !== 8'd0) begin errors++; $display("FAIL sbe_cnt0 got %0d exp 0", sbe_cnt[7:0]); end
        step();
        checks++; if (irq !== CNT_EN) begin errors++; $display("FAIL irq_set got %b exp %b", irq, CNT_EN); end
        mode = 3'd0; en = 2'b00; bus.dbe_i = 4'b1111; bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL err_unsel got %b exp 0000", bus.err_o); end
        checks++; if (dbe_cnt !== (CNT_EN ? 32'h0000_0001 : 32'h0)) begin errors++; $display("FAIL dbe_unsel got %h", dbe_cnt); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++; if ({irq, dbe_cnt} !== '0) begin errors++; $display("FAIL clr got irq%b %h exp 0", irq, dbe_cnt); end
        bus.sbe_i = '0; bus.dbe_i = '0;
    endtask

    task automatic test_saturate();
        mode = 3'd4; en = 2'b01; bus.ready_i = 1'b1;
        bus.sbe_i = 4'b0011; bus.valid_i = 1'b1;
        for (int i = 0; i < 300; i++) step();
        checks++; if (sbe_cnt[7:0] !== (CNT_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat got %0d exp %0d", sbe_cnt[7:0], CNT_EN ? 255 : 0); end
        checks++; if (sbe_cnt[15:8] !== 8'd0) begin errors++; $display("FAIL sat_ch1 got %0d exp 0", sbe_cnt[15:8]); end
        mode = 3'd2;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++; if (sbe_cnt !== '0) begin errors++; $display("FAIL clr_inc got %h exp 0", sbe_cnt); end
        step();
        checks++; if (sbe_cnt !== (CNT_EN ? 32'h0000_0101 : 32'h0)) begin errors++; $display("FAIL post_clr got %h", sbe_cnt); end
        bus.valid_i = 1'b0; bus.sbe_i = '0;
        step();
    endtask

    task automatic test_reset_midstream();
        mode = 3'd2; en = 2'b01; bus.ready_i = 1'b0;
        bus.dbe_i = 4'b0001; bus.valid_i = 1'b1;
        step();
        step();
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.ready_o); end
        bus.valid_i = 1'b0; bus.dbe_i = '0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({bus.valid_o, bus.ready_o} !== 2'b01) begin errors++; $display("FAIL rst_mid got v%b r%b exp v0 r1", bus.valid_o, bus.ready_o); end
        checks++; if ({dbe_cnt, irq} !== '0) begin errors++; $display("FAIL rst_mid_cnt got %h irq%b exp 0", dbe_cnt, irq); end
        bus.ready_i = 1'b1;
        step();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_ghost got %b exp 0", bus.valid_o); end
    endtask

    initial begin
        rst = 1'b1; mode = '0; en = '0; cnt_clr = 1'b0;
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        bus.data_i = '0; bus.data_ecc_i = '0; bus.sbe_i = '0; bus.dbe_i = '0;
        test_reset();
        test_select();
        test_stall();
        test_counters();
        test_saturate();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
